// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART RX datapath blocks.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_deser_state_e;

  // Shortest word the deserializer accepts after clamping.
  localparam int MIN_LEN_DEF = 5;

  // Last oversample edge index of a bit period; the bit is committed here.
  function automatic int cnt_max(input int cw);
    return (1 << cw) - 1;
  endfunction

  // Centre oversample edge index of a bit period.
  function automatic int mid(input int cw);
    return 1 << (cw - 1);
  endfunction

endpackage

// File: rtl/rx_bit_voter.sv
// Three-point majority voter around the centre of a bit period.
// Used by rx_deserializer_cfg only when RX_DESER_MAJORITY_EN is defined.
module rx_bit_voter
  import uart_rx_pkg::*;
#(
  parameter int COUNTER_WIDTH = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     Enable,
  input  logic                     Sbit,
  input  logic [COUNTER_WIDTH-1:0] edg_cnt,
  output logic                     vote
);

  localparam int MID = mid(COUNTER_WIDTH);
  localparam logic [COUNTER_WIDTH-1:0] PT_LO = COUNTER_WIDTH'(MID - 1);
  localparam logic [COUNTER_WIDTH-1:0] PT_MD = COUNTER_WIDTH'(MID);
  localparam logic [COUNTER_WIDTH-1:0] PT_HI = COUNTER_WIDTH'(MID + 1);

  logic [2:0] smp;

  // Capture Sbit at the three points straddling the bit centre.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp <= '0;
    end else if (clr) begin
      smp <= '0;
    end else if (Enable) begin
      if (edg_cnt == PT_LO) smp[0] <= Sbit;
      if (edg_cnt == PT_MD) smp[1] <= Sbit;
      if (edg_cnt == PT_HI) smp[2] <= Sbit;
    end
  end

  assign vote = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/rx_deserializer_cfg.sv
// UART RX deserializer: collects committed serial bits into a parallel word
// with run-time length and bit order. P_DATA only changes when a complete
// word lands, together with a one-cycle data_vld strobe.
// Optional: RX_DESER_MAJORITY_EN replaces the single end-of-bit sample with
// a 3-point majority vote around the bit centre (rx_bit_voter).
module rx_deserializer_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 3,
  parameter int MIN_LEN       = MIN_LEN_DEF,
  parameter int LEN_WIDTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Enable,
  input  logic                     Sbit,
  input  logic [COUNTER_WIDTH-1:0] edg_cnt,
  input  logic [LEN_WIDTH-1:0]     data_len,
  input  logic                     msb_first,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     data_vld,
  output logic                     busy,
  output logic [LEN_WIDTH-1:0]     bit_idx,
  output logic                     abort
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(cnt_max(COUNTER_WIDTH));

  // Saturate a requested word length into MIN_LEN..DATA_WIDTH.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
    if (int'(l) < MIN_LEN)    return LEN_WIDTH'(MIN_LEN);
    if (int'(l) > DATA_WIDTH) return LEN_WIDTH'(DATA_WIDTH);
    return l;
  endfunction

  // Right-justify the received bits; LSB-first words sit at the top of the
  // shift register, MSB-first words at the bottom.
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] sr,
                                                    input logic [LEN_WIDTH-1:0]  len,
                                                    input logic                  ord);
    int sh;
    sh = DATA_WIDTH - int'(len);
    if (ord) return sr & ({DATA_WIDTH{1'b1}} >> sh);
    return sr >> sh;
  endfunction

  rx_deser_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0]    sr_q, sr_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic                     ord_q, ord_d;
  logic [LEN_WIDTH-1:0]     idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    pdata_q, pdata_d;
  logic                     vld_q, vld_d;
  logic                     abort_q, abort_d;
  logic                     commit;
  logic                     bit_c;

  assign commit = Enable && (edg_cnt == CNT_MAX);

`ifdef RX_DESER_MAJORITY_EN
  logic vote;
  logic vote_clr;

  assign vote_clr = (state_d == IDLE) && (state_q != IDLE);

  rx_bit_voter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_voter (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (vote_clr),
    .Enable (Enable),
    .Sbit   (Sbit),
    .edg_cnt(edg_cnt),
    .vote   (vote)
  );

  assign bit_c = vote;
`else
  assign bit_c = Sbit;
`endif

  // Word assembly FSM: next state, shift register and output strobes.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    len_d   = len_q;
    ord_d   = ord_q;
    idx_d   = idx_q;
    pdata_d = pdata_q;
    vld_d   = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE is a single cycle; a commit landing here opens the next word.
        state_d = IDLE;
        idx_d   = '0;
        if (commit) begin
          len_d   = clamp_len(data_len);
          ord_d   = msb_first;
          sr_d    = msb_first ? {{(DATA_WIDTH-1){1'b0}}, bit_c}
                              : {bit_c, {(DATA_WIDTH-1){1'b0}}};
          idx_d   = LEN_WIDTH'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!Enable) begin
          abort_d = 1'b1;
          idx_d   = '0;
          sr_d    = '0;
          state_d = IDLE;
        end else if (commit) begin
          sr_d  = ord_q ? {sr_q[DATA_WIDTH-2:0], bit_c} : {bit_c, sr_q[DATA_WIDTH-1:1]};
          idx_d = idx_q + LEN_WIDTH'(1);
          if (idx_d == len_q) begin
            pdata_d = extract(sr_d, len_q, ord_q);
            vld_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      len_q   <= LEN_WIDTH'(DATA_WIDTH);
      ord_q   <= 1'b0;
      idx_q   <= '0;
      pdata_q <= '0;
      vld_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      ord_q   <= ord_d;
      idx_q   <= idx_d;
      pdata_q <= pdata_d;
      vld_q   <= vld_d;
      abort_q <= abort_d;
    end
  end

  assign P_DATA   = pdata_q;
  assign data_vld = vld_q;
  assign busy     = (state_q == SHIFT);
  assign bit_idx  = idx_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_rx_deserializer_cfg.sv
// Self-checking bench for rx_deserializer_cfg: directed words plus randomized
// words (length, order, data, mid-word input changes, aborts) checked against
// a word-level reference model.
module tb_rx_deserializer_cfg;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Enable;
  logic       Sbit;
  logic [2:0] edg_cnt;
  logic [3:0] data_len;
  logic       msb_first;
  logic [7:0] P_DATA;
  logic       data_vld;
  logic       busy;
  logic [3:0] bit_idx;
  logic       abort;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] prev  = 8'h00;

  rx_deserializer_cfg #(
    .DATA_WIDTH   (8),
    .COUNTER_WIDTH(3),
    .MIN_LEN      (5),
    .LEN_WIDTH    (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Enable   (Enable),
    .Sbit     (Sbit),
    .edg_cnt  (edg_cnt),
    .data_len (data_len),
    .msb_first(msb_first),
    .P_DATA   (P_DATA),
    .data_vld (data_vld),
    .busy     (busy),
    .bit_idx  (bit_idx),
    .abort    (abort)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int l);
    if (l < 5) return 5;
    if (l > 8) return 8;
    return l;
  endfunction

  // Reference: serial bit i lands at word bit i (LSB first) or len-1-i (MSB first).
  function automatic logic [7:0] model_word(input int len, input logic ord, input logic [7:0] bits);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (bits[i]) begin
        if (ord) w[len-1-i] = 1'b1;
        else     w[i] = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full bit period; pat[e] is Sbit at oversample edge e.
  task automatic drive_bit(input logic [7:0] pat);
    for (int e = 0; e < 8; e++) begin
      Enable  = 1'b1;
      Sbit    = pat[e];
      edg_cnt = 3'(e);
      tick();
    end
  endtask

  // Send a word; chg_len >= 0 changes data_len/msb_first after the first bit;
  // abort_after > 0 drops Enable after that many commits.
  task automatic run_word(input int len_in, input logic ord, input logic [7:0] bits,
                          input int chg_len, input int abort_after);
    int         eff;
    int         nb;
    logic [7:0] exp;
    eff = clamp(len_in);
    exp = model_word(eff, ord, bits);
    nb  = (abort_after > 0) ? abort_after : eff;
    data_len  = 4'(len_in);
    msb_first = ord;
    for (int i = 0; i < nb; i++) begin
      drive_bit({8{bits[i]}});
      if (i == 0 && chg_len >= 0) begin
        data_len  = 4'(chg_len);
        msb_first = ~ord;
      end
      if (i < eff - 1) begin
        check("busy_mid", 32'(busy), 32'd1);
        check("bit_idx_mid", 32'(bit_idx), 32'(i + 1));
        check("vld_early", 32'(data_vld), 32'd0);
      end else begin
        check("vld_pulse", 32'(data_vld), 32'd1);
        check("p_data", 32'(P_DATA), 32'(exp));
      end
    end
    Enable  = 1'b0;
    Sbit    = 1'b0;
    edg_cnt = 3'd0;
    tick();
    if (abort_after > 0) begin
      check("abort_pulse", 32'(abort), 32'd1);
      check("p_data_hold", 32'(P_DATA), 32'(prev));
    end else begin
      check("abort_none", 32'(abort), 32'd0);
      check("p_data_stable", 32'(P_DATA), 32'(exp));
      prev = exp;
    end
    check("busy_after", 32'(busy), 32'd0);
    check("bit_idx_after", 32'(bit_idx), 32'd0);
    check("vld_after", 32'(data_vld), 32'd0);
    tick();
    check("abort_clear", 32'(abort), 32'd0);
  endtask

  initial begin
    int         len_in;
    logic       ord;
    logic [7:0] bits;
    int         chg;
    int         ab;

    RST = 1'b0; Enable = 1'b0; Sbit = 1'b0; edg_cnt = 3'd0;
    data_len = 4'd8; msb_first = 1'b0;
    tick(); tick();
    check("rst_p_data", 32'(P_DATA), 32'd0);
    check("rst_vld", 32'(data_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    RST = 1'b1;
    tick();

    // Directed words
    run_word(8, 1'b0, 8'hA5, -1, 0);    // serial 1,0,1,0,0,1,0,1 -> A5
    run_word(8, 1'b0, 8'h3C, -1, 4);    // abort after 4 commits, A5 held
    run_word(5, 1'b0, 8'h0B, -1, 0);    // serial 1,1,0,1,0 -> 0B
    run_word(7, 1'b1, 8'h41, -1, 0);    // MSB first, serial 1,0,0,0,0,0,1 -> 41
    run_word(8, 1'b0, 8'h96, 6, 0);     // data_len changed mid-word, still 8 bits
    run_word(3, 1'b0, 8'h1D, -1, 0);    // clamped to 5
    run_word(12, 1'b1, 8'hC3, -1, 0);   // clamped to 8

    // Sampling-point behaviour on the first bit of a 5-bit LSB-first word
    data_len = 4'd5; msb_first = 1'b0;
`ifdef RX_DESER_MAJORITY_EN
    drive_bit(8'hEF);                   // glitch at centre edge only -> 1
    for (int i = 1; i < 5; i++) drive_bit(8'hFF);
    check("majority_word", 32'(P_DATA), 32'h1F);
    prev = 8'h1F;
`else
    drive_bit(8'h7F);                   // 0 only at last edge -> 0
    for (int i = 1; i < 5; i++) drive_bit(8'hFF);
    check("endsample_word", 32'(P_DATA), 32'h1E);
    prev = 8'h1E;
`endif
    check("sample_vld", 32'(data_vld), 32'd1);
    Enable = 1'b0; edg_cnt = 3'd0;
    tick(); tick();

    // Randomized words
    for (int n = 0; n < 30; n++) begin
      len_in = int'($urandom_range(0, 15));
      ord    = 1'($urandom_range(0, 1));
      bits   = 8'($urandom);
      chg    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      ab     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, clamp(len_in) - 1)) : 0;
      run_word(len_in, ord, bits, chg, ab);
    end

    // Reset in the middle of a word
    data_len = 4'd8; msb_first = 1'b0;
    drive_bit(8'hFF); drive_bit(8'h00); drive_bit(8'hFF);
    #2 RST = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bit_idx", 32'(bit_idx), 32'd0);
    check("midrst_p_data", 32'(P_DATA), 32'd0);
    Enable = 1'b0;
    tick();
    RST  = 1'b1;
    prev = 8'h00;
    tick();
    run_word(6, 1'b1, 8'h2D, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
